pwm_generator_mc: RTL and testbench

- Parametrised multi-channel successor to the single-channel PWM generator.
- NUM_CH independent PWM channels, each with its own period, duty and mode, all programmed through one shared write port.
- Duty is an absolute tick count, not a percentage.
- Period and duty are double-buffered (shadow → active at period boundary) for glitch-free updates.
- Per-channel edge- or centre-aligned mode, output inversion, and a global sync restart.
- Sits between the host register interface and motor/LED drive pins.

---
 rtl/pwm_generator_mc_if.sv | 21 ++
 rtl/pwm_generator_mc.sv | 165 ++++++++++++++++
 tb/tb_pwm_generator_mc.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_generator_mc_if.sv
// pwm_generator_mc_if
// Shared host write port for the multi-channel PWM generator.
//   in     : write data (period, duty or ctrl bits)
//   addr   : channel select for the write
//   sel    : register select (00 duty, 01 period, 10 ctrl, 11 reserved)
//   wr_en  : write strobe, at most one write per cycle
//   sync   : one-cycle pulse restarting every channel counter
// master modport = host side, slave modport = PWM generator side.
interface pwm_generator_mc_if #(
  parameter int WIDTH = 12,
  parameter int AW    = 2
);
  logic [WIDTH-1:0] in;
  logic [AW-1:0]    addr;
  logic [1:0]       sel;
  logic             wr_en;
  logic             sync;

  modport master (output in, addr, sel, wr_en, sync);
  modport slave  (input  in, addr, sel, wr_en, sync);
endinterface

// File: rtl/pwm_generator_mc.sv
// pwm_generator_mc
// NUM_CH independent PWM channels programmed through one shared write port.
// Period and duty are double-buffered: writes land in shadow registers and
// are copied to the active registers on a load event (period boundary, sync,
// or continuously while the channel is disabled). Ctrl bits act immediately.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active HIGH despite the name
//   bus        : host write port (pwm_generator_mc_if.slave)
//   pwm_out    : registered PWM outputs, bit i = channel i
//   period_end : registered one-cycle pulse after each channel boundary
module pwm_generator_mc #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 12,
  parameter int AW     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_generator_mc_if.slave    bus,
  output logic [NUM_CH-1:0]    pwm_out,
  output logic [NUM_CH-1:0]    period_end
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] sh_period_q  [NUM_CH];
  logic [WIDTH-1:0] sh_period_d  [NUM_CH];
  logic [WIDTH-1:0] sh_duty_q    [NUM_CH];
  logic [WIDTH-1:0] sh_duty_d    [NUM_CH];
  logic [WIDTH-1:0] act_period_q [NUM_CH];
  logic [WIDTH-1:0] act_period_d [NUM_CH];
  logic [WIDTH-1:0] act_duty_q   [NUM_CH];
  logic [WIDTH-1:0] act_duty_d   [NUM_CH];
  logic [WIDTH-1:0] cnt_q        [NUM_CH];
  logic [WIDTH-1:0] cnt_d        [NUM_CH];
  logic [2:0]       ctrl_q       [NUM_CH];
  logic [2:0]       ctrl_d       [NUM_CH];
  dir_t             dir_q        [NUM_CH];
  dir_t             dir_d        [NUM_CH];

  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] pe_q, pe_d;
  logic [NUM_CH-1:0] running, boundary, load;
  logic              wr_hit;

  // Writes to non-existent channels or the reserved register are dropped.
  assign wr_hit = bus.wr_en && (32'(bus.addr) < 32'(NUM_CH)) && (bus.sel != 2'b11);

  // Shadow and ctrl register updates from the host port.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sh_period_d[ch] = sh_period_q[ch];
      sh_duty_d[ch]   = sh_duty_q[ch];
      ctrl_d[ch]      = ctrl_q[ch];
      if (wr_hit && (bus.addr == AW'(ch))) begin
        case (bus.sel)
          2'b00:   sh_duty_d[ch]   = bus.in;
          2'b01:   sh_period_d[ch] = bus.in;
          2'b10:   ctrl_d[ch]      = bus.in[2:0];
          default: ;
        endcase
      end
    end
  end

  // Per-channel status: is the counter running, is this the boundary cycle,
  // and does the active register set reload on this edge.
  // Centre mode with P=2 peaks at 1 and returns straight to 0, so the peak
  // itself is the boundary; with P=1 every cycle is a boundary.
  always_comb begin
    running  = '0;
    boundary = '0;
    load     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      running[ch] = ctrl_q[ch][0] && (act_period_q[ch] != '0);
      if (ctrl_q[ch][2]) begin
        if (act_period_q[ch] == ONE)
          boundary[ch] = running[ch];
        else if (dir_q[ch] == DIR_DOWN)
          boundary[ch] = running[ch] && (cnt_q[ch] == ONE);
        else
          boundary[ch] = running[ch] && (act_period_q[ch] == TWO) &&
                         (cnt_q[ch] == ONE);
      end else begin
        boundary[ch] = running[ch] && (cnt_q[ch] == act_period_q[ch] - ONE);
      end
      load[ch] = !ctrl_q[ch][0] || bus.sync || boundary[ch];
    end
  end

  // Counter / direction next state and registered output levels.
  // A load always takes the shadow value present before this edge, so a
  // write landing on the same edge only appears at the following load.
  always_comb begin
    pwm_d = '0;
    pe_d  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      act_period_d[ch] = act_period_q[ch];
      act_duty_d[ch]   = act_duty_q[ch];
      cnt_d[ch]        = cnt_q[ch];
      dir_d[ch]        = dir_q[ch];

      pwm_d[ch] = running[ch] ? ((cnt_q[ch] < act_duty_q[ch]) ^ ctrl_q[ch][1])
                              : ctrl_q[ch][1];
      pe_d[ch]  = running[ch] && (bus.sync || boundary[ch]);

      if (load[ch]) begin
        act_period_d[ch] = sh_period_q[ch];
        act_duty_d[ch]   = sh_duty_q[ch];
        cnt_d[ch]        = '0;
        dir_d[ch]        = DIR_UP;
      end else if (running[ch]) begin
        if (!ctrl_q[ch][2]) begin
          cnt_d[ch] = cnt_q[ch] + ONE;
          dir_d[ch] = DIR_UP;
        end else if (dir_q[ch] == DIR_DOWN) begin
          cnt_d[ch] = cnt_q[ch] - ONE;
        end else if (cnt_q[ch] == act_period_q[ch] - ONE) begin
          cnt_d[ch] = cnt_q[ch] - ONE;
          dir_d[ch] = DIR_DOWN;
        end else begin
          cnt_d[ch] = cnt_q[ch] + ONE;
        end
      end else begin
        cnt_d[ch] = '0;
        dir_d[ch] = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sh_period_q[ch]  <= '0;
        sh_duty_q[ch]    <= '0;
        act_period_q[ch] <= '0;
        act_duty_q[ch]   <= '0;
        cnt_q[ch]        <= '0;
        ctrl_q[ch]       <= '0;
        dir_q[ch]        <= DIR_UP;
      end
      pwm_q <= '0;
      pe_q  <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        sh_period_q[ch]  <= sh_period_d[ch];
        sh_duty_q[ch]    <= sh_duty_d[ch];
        act_period_q[ch] <= act_period_d[ch];
        act_duty_q[ch]   <= act_duty_d[ch];
        cnt_q[ch]        <= cnt_d[ch];
        ctrl_q[ch]       <= ctrl_d[ch];
        dir_q[ch]        <= dir_d[ch];
      end
      pwm_q <= pwm_d;
      pe_q  <= pe_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_generator_mc.sv
// tb_pwm_generator_mc
// Bench for pwm_generator_mc with three channels on a two-bit address, so
// address 3 addresses no channel. A reference model tracks each channel as a
// phase position within its period and derives counter value, compare level
// and boundary from that position.
module tb_pwm_generator_mc;
  localparam int NUM_CH = 3;
  localparam int WIDTH  = 12;
  localparam int AW     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [NUM_CH-1:0] pwm_out;
  logic [NUM_CH-1:0] period_end;

  int check_cnt = 0;
  int pass_cnt  = 0;

  pwm_generator_mc_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  pwm_generator_mc #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_sp  [NUM_CH];
  int         m_sd  [NUM_CH];
  logic [2:0] m_ctl [NUM_CH];
  int         m_ap  [NUM_CH];
  int         m_ad  [NUM_CH];
  int         m_ph  [NUM_CH];
  logic [NUM_CH-1:0] exp_pwm;
  logic [NUM_CH-1:0] exp_pe;

  // Every comparison in the bench goes through here.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    check_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
  endtask

  task automatic modelReset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      m_sp[ch] = 0; m_sd[ch] = 0; m_ctl[ch] = 3'b000;
      m_ap[ch] = 0; m_ad[ch] = 0; m_ph[ch] = 0;
    end
    exp_pwm = '0;
    exp_pe  = '0;
  endtask

  // One clock of the reference model using the inputs currently driven.
  task automatic modelStep();
    logic [NUM_CH-1:0] nxt_pwm, nxt_pe;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit en, inv, centre, run, bnd;
      int len, c;
      en     = m_ctl[ch][0];
      inv    = m_ctl[ch][1];
      centre = m_ctl[ch][2];
      run    = en && (m_ap[ch] != 0);
      if (centre) len = (m_ap[ch] <= 1) ? 1 : 2 * (m_ap[ch] - 1);
      else        len = m_ap[ch];
      c = (centre && m_ph[ch] >= m_ap[ch]) ? 2 * (m_ap[ch] - 1) - m_ph[ch] : m_ph[ch];
      bnd = run && (m_ph[ch] == len - 1);
      nxt_pwm[ch] = run ? ((c < m_ad[ch]) ^ inv) : inv;
      nxt_pe[ch]  = run && (bus.sync || bnd);
      if (!en || bus.sync || bnd) begin
        m_ph[ch] = 0;
        m_ap[ch] = m_sp[ch];
        m_ad[ch] = m_sd[ch];
      end else if (run) begin
        m_ph[ch] = m_ph[ch] + 1;
      end
    end
    if (bus.wr_en && int'(bus.addr) < NUM_CH) begin
      case (bus.sel)
        2'b00: m_sd[bus.addr]  = int'(bus.in);
        2'b01: m_sp[bus.addr]  = int'(bus.in);
        2'b10: m_ctl[bus.addr] = bus.in[2:0];
        default: ;
      endcase
    end
    exp_pwm = nxt_pwm;
    exp_pe  = nxt_pe;
  endtask

  task automatic applyStimulus(input logic wr, input int a, input int s, input int d, input logic sy);
    bus.wr_en = wr;
    bus.addr  = a[AW-1:0];
    bus.sel   = s[1:0];
    bus.in    = d[WIDTH-1:0];
    bus.sync  = sy;
  endtask

  task automatic checkOutput();
    checkVal("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    checkVal("period_end", 32'(period_end), 32'(exp_pe));
  endtask

  task automatic stepCycle();
    if (rst_n) modelReset();
    else       modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic writeReg(input int a, input int s, input int d);
    applyStimulus(1'b1, a, s, d, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runCount(input int n, input int ch, output int highs, output int pes);
    highs = 0;
    pes   = 0;
    for (int i = 0; i < n; i++) begin
      stepCycle();
      highs += int'(pwm_out[ch]);
      pes   += int'(period_end[ch]);
    end
  endtask

  initial begin
    int highs, pes, guard, data, a, s;
    logic [2:0] nc;
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    modelReset();

    // Reset state
    #2;
    checkVal("reset_pwm", 32'(pwm_out), 32'd0);
    checkVal("reset_pe", 32'(period_end), 32'd0);
    runCycles(2);
    rst_n = 1'b0;
    runCycles(3);

    // Edge mode basic: ch0 P=10 D=3
    writeReg(0, 1, 10);
    writeReg(0, 0, 3);
    writeReg(0, 2, 3'b001);
    stepCycle();
    runCount(20, 0, highs, pes);
    checkVal("edge_highs", 32'(highs), 32'd6);
    checkVal("edge_pe", 32'(pes), 32'd2);

    // Shadow update mid-period, then a write landing on the boundary edge
    runCycles(4);
    writeReg(0, 0, 7);
    runCycles(22);
    guard = 0;
    while (m_ph[0] != 9 && guard < 20) begin
      stepCycle();
      guard++;
    end
    checkVal("bnd_wait", 32'(guard < 20), 32'd1);
    writeReg(0, 0, 5);
    runCycles(25);

    // Centre mode: ch1 P=5 D=2
    writeReg(1, 1, 5);
    writeReg(1, 0, 2);
    writeReg(1, 2, 3'b101);
    stepCycle();
    runCount(16, 1, highs, pes);
    checkVal("centre_pe", 32'(pes), 32'd2);

    // Limits on ch2
    writeReg(2, 1, 10);
    writeReg(2, 0, 0);
    writeReg(2, 2, 3'b001);
    runCount(12, 2, highs, pes);
    checkVal("duty0_highs", 32'(highs), 32'd0);
    writeReg(2, 0, 12);
    runCycles(12);
    runCount(10, 2, highs, pes);
    checkVal("duty_over_p_highs", 32'(highs), 32'd10);
    writeReg(2, 1, 0);
    runCycles(12);
    runCount(12, 2, highs, pes);
    checkVal("p0_highs", 32'(highs), 32'd0);
    checkVal("p0_pe", 32'(pes), 32'd0);
    writeReg(2, 2, 3'b011);
    stepCycle();
    runCount(12, 2, highs, pes);
    checkVal("p0_inv_highs", 32'(highs), 32'd12);
    writeReg(2, 0, 0);
    writeReg(2, 1, 10);
    writeReg(2, 2, 3'b010);
    writeReg(2, 2, 3'b011);
    stepCycle();
    runCount(12, 2, highs, pes);
    checkVal("inv_d0_highs", 32'(highs), 32'd12);

    // Multi-channel sync
    writeReg(0, 1, 8);
    writeReg(2, 0, 4);
    writeReg(2, 1, 12);
    writeReg(2, 2, 3'b001);
    runCycles(5);
    applyStimulus(1'b0, 0, 0, 0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    checkVal("sync_pe", 32'(period_end & 3'b101), 32'h5);
    runCycles(30);

    // Writes to a missing channel and to the reserved register
    writeReg(3, 1, 5);
    writeReg(3, 2, 3'b000);
    writeReg(0, 3, 1);
    runCycles(30);

    // Asynchronous reset during a high phase of ch0
    guard = 0;
    while (exp_pwm[0] !== 1'b1 && guard < 20) begin
      stepCycle();
      guard++;
    end
    checkVal("high_wait", 32'(guard < 20), 32'd1);
    #2;
    rst_n = 1'b1;
    #1;
    modelReset();
    checkVal("async_rst_pwm", 32'(pwm_out), 32'd0);
    checkVal("async_rst_pe", 32'(period_end), 32'd0);
    runCycles(2);
    rst_n = 1'b0;
    runCycles(10);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a = int'($urandom_range(0, 3));
      s = int'($urandom_range(0, 3));
      case (s)
        0: data = int'($urandom_range(0, 23));
        1: data = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
        default: begin
          nc = 3'($urandom_range(0, 7));
          if (a < NUM_CH && m_ctl[a][0] && nc[0]) nc[2] = m_ctl[a][2];
          data = int'(nc);
        end
      endcase
      applyStimulus(($urandom_range(0, 2) == 0), a, s, data, ($urandom_range(0, 59) == 0));
      stepCycle();
    end
    applyStimulus(1'b0, 0, 0, 0, 1'b0);
    runCycles(5);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
